// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
// Gives the hiscore module safe access to the game core's work RAM.
// To do that it pauses the CPU, waits for the halt acknowledge plus a settle
// interval, and then hands the RAM port to the hiscore side. It also merges
// the user/OSD pause into the single active-low core pause line.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   hs_req            hiscore access request (level)
//   hs_addr/hs_wdata  hiscore address / write data
//   hs_we             hiscore write strobe (acted on only while granted)
//   hs_gnt            RAM port granted to the hiscore side
//   hs_rdata          registered RAM read data back to the hiscore side
//   hs_busy           arbiter not idle
//   user_pause        user/OSD pause (level)
//   cpu_halted        core acknowledge that the CPU is stopped
//   cpu_pause_n       pause to the core, active-low
//   ram_sel           1 = hiscore side drives the RAM port
//   ram_addr/ram_wdata/ram_we  registered RAM port drive
//   ram_rdata         synchronous RAM read data (1-cycle latency)
//   timeout_err       one-cycle pulse when the halt acknowledge never came
module hs_ram_arbiter #(
  parameter int AW      = 16,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_wdata,
  input  logic          hs_we,
  output logic          hs_gnt,
  output logic [7:0]    hs_rdata,
  output logic          hs_busy,
  input  logic          user_pause,
  input  logic          cpu_halted,
  output logic          cpu_pause_n,
  output logic          ram_sel,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata,
  output logic          timeout_err
);

  localparam int CNT_MAXV = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW       = $clog2(CNT_MAXV) + 1;

  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};
  localparam logic [CW-1:0] TIMEOUT_END = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_END  = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_SETTLE  = 3'd2,
    S_GRANT   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tmo_s;

  logic          gnt_r;
  logic          ram_sel_r;
  logic          ram_we_r;
  logic          pause_n_r;
  logic          tmo_r;
  logic [AW-1:0] ram_addr_r;
  logic [7:0]    ram_wdata_r;
  logic [7:0]    hs_rdata_r;

  // The counter saturates so a long wait can never wrap back into range.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_SAT) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Next-state, counter and timeout decision.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tmo_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (hs_req) begin
          state_nxt_s = S_HALT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_HALT: begin
        // Abort beats acknowledge, acknowledge beats timeout.
        if (!hs_req) begin
          state_nxt_s = S_RELEASE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cpu_halted) begin
          state_nxt_s = S_SETTLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_END) begin
          state_nxt_s = S_RELEASE;
          cnt_nxt_s   = CNT_ZERO;
          tmo_s       = 1'b1;
        end else begin
          cnt_nxt_s   = sat_inc(cnt_r);
        end
      end
      S_SETTLE: begin
        if (!hs_req) begin
          state_nxt_s = S_RELEASE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (!cpu_halted) begin
          state_nxt_s = S_HALT;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == SETTLE_END) begin
          state_nxt_s = S_GRANT;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = sat_inc(cnt_r);
        end
      end
      S_GRANT: begin
        cnt_nxt_s = CNT_ZERO;
        if (!hs_req) begin
          state_nxt_s = S_RELEASE;
        end else begin
          state_nxt_s = S_GRANT;
        end
      end
      S_RELEASE: begin
        // Always pass through IDLE so back-to-back requests get a gap.
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Control outputs, registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_r     <= 1'b0;
      ram_sel_r <= 1'b0;
      ram_we_r  <= 1'b0;
      pause_n_r <= 1'b1;
      tmo_r     <= 1'b0;
    end else begin
      gnt_r     <= (state_nxt_s == S_GRANT);
      ram_sel_r <= (state_nxt_s == S_GRANT);
      // A write seen in the last GRANT cycle must not leak into RELEASE.
      ram_we_r  <= hs_we && (state_r == S_GRANT) && (state_nxt_s == S_GRANT);
      pause_n_r <= ~(user_pause | (state_nxt_s != S_IDLE));
      tmo_r     <= tmo_s;
    end
  end

  // RAM address/data track the hiscore side while granted and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_r  <= {AW{1'b0}};
      ram_wdata_r <= 8'h00;
    end else if (state_r == S_GRANT) begin
      ram_addr_r  <= hs_addr;
      ram_wdata_r <= hs_wdata;
    end else begin
      ram_addr_r  <= ram_addr_r;
      ram_wdata_r <= ram_wdata_r;
    end
  end

  // Read data capture while the hiscore side owns the RAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_rdata_r <= 8'h00;
    end else if (ram_sel_r) begin
      hs_rdata_r <= ram_rdata;
    end else begin
      hs_rdata_r <= hs_rdata_r;
    end
  end

  assign hs_gnt      = gnt_r;
  assign ram_sel     = ram_sel_r;
  assign ram_we      = ram_we_r;
  assign cpu_pause_n = pause_n_r;
  assign timeout_err = tmo_r;
  assign ram_addr    = ram_addr_r;
  assign ram_wdata   = ram_wdata_r;
  assign hs_rdata    = hs_rdata_r;
  assign hs_busy     = (state_r != S_IDLE);

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter with a small synchronous RAM model.
// Cycle k below means "just after clock edge k"; inputs changed in cycle k
// are sampled at edge k+1.
module tb_hs_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hs_req;
  logic [15:0] hs_addr;
  logic [7:0]  hs_wdata;
  logic        hs_we;
  logic        hs_gnt;
  logic [7:0]  hs_rdata;
  logic        hs_busy;
  logic        user_pause;
  logic        cpu_halted;
  logic        cpu_pause_n;
  logic        ram_sel;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  hs_ram_arbiter #(.AW(16), .SETTLE(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we),
    .hs_gnt(hs_gnt), .hs_rdata(hs_rdata), .hs_busy(hs_busy),
    .user_pause(user_pause), .cpu_halted(cpu_halted), .cpu_pause_n(cpu_pause_n),
    .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write and read both registered, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hs_req = 1'b0; hs_addr = 16'h0000; hs_wdata = 8'h00;
    hs_we = 1'b0; user_pause = 1'b0; cpu_halted = 1'b0;
    step(2);
    // Reset state
    chk("rst_pause_n", cpu_pause_n, 1); chk("rst_gnt", hs_gnt, 0);
    chk("rst_ram_sel", ram_sel, 0);     chk("rst_ram_we", ram_we, 0);
    chk("rst_tmo", timeout_err, 0);     chk("rst_busy", hs_busy, 0);
    chk("rst_ram_addr", ram_addr, 0);   chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", hs_rdata, 0);
    reset = 1'b0;
    step(2);
    chk("idle_busy", hs_busy, 0);

    // Basic grant: req in cycle 0, halt ack in cycle 3, grant from cycle 8
    hs_req = 1'b1;                          // cycle 0
    step(1);                                // cycle 1
    chk("bg_pause_c1", cpu_pause_n, 0); chk("bg_busy_c1", hs_busy, 1);
    chk("bg_gnt_c1", hs_gnt, 0);
    step(2); cpu_halted = 1'b1;             // cycle 3
    step(4);                                // cycle 7
    chk("bg_gnt_c7", hs_gnt, 0); chk("bg_sel_c7", ram_sel, 0);
    step(1);                                // cycle 8
    chk("bg_gnt_c8", hs_gnt, 1); chk("bg_sel_c8", ram_sel, 1);

    // Write 0xA5 -> 0x1234, 0x3C -> 0x0042, then read both back
    hs_addr = 16'h1234; hs_wdata = 8'hA5; hs_we = 1'b1;
    step(1);                                // cycle 9
    chk("wr1_we", ram_we, 1); chk("wr1_addr", ram_addr, 32'h1234);
    chk("wr1_data", ram_wdata, 32'hA5);
    hs_addr = 16'h0042; hs_wdata = 8'h3C;
    step(1);                                // cycle 10
    chk("wr2_we", ram_we, 1); chk("wr2_addr", ram_addr, 32'h0042);
    chk("wr2_data", ram_wdata, 32'h3C);
    hs_we = 1'b0; hs_addr = 16'h1234;
    step(1);                                // cycle 11
    chk("rd_we_off", ram_we, 0); chk("rd1_addr", ram_addr, 32'h1234);
    hs_addr = 16'h0042;
    step(2);                                // cycle 13
    chk("rd1_data", hs_rdata, 32'hA5);
    step(1);                                // cycle 14
    chk("rd2_data", hs_rdata, 32'h3C);
    hs_req = 1'b0; cpu_halted = 1'b0;
    step(1);                                // cycle 15: RELEASE
    chk("rel_gnt", hs_gnt, 0); chk("rel_sel", ram_sel, 0);
    chk("rel_pause", cpu_pause_n, 0); chk("rel_busy", hs_busy, 1);
    chk("rel_we", ram_we, 0);
    step(1);                                // cycle 16: IDLE
    chk("idle_busy2", hs_busy, 0); chk("idle_pause2", cpu_pause_n, 1);
    chk("rdata_hold", hs_rdata, 32'h3C);
    step(2);

    // Timeout: no halt ack; req kept high through RELEASE
    hs_req = 1'b1;                          // cycle 0
    step(16);                               // cycle 16
    chk("to_err_c16", timeout_err, 0); chk("to_busy_c16", hs_busy, 1);
    step(1);                                // cycle 17
    chk("to_err_c17", timeout_err, 1); chk("to_pause_c17", cpu_pause_n, 0);
    chk("to_sel_c17", ram_sel, 0);
    step(1);                                // cycle 18
    chk("to_err_c18", timeout_err, 0); chk("to_busy_c18", hs_busy, 0);
    chk("to_pause_c18", cpu_pause_n, 1);
    hs_req = 1'b0;
    step(3);

    // Abort in SETTLE; halt already present before the request
    cpu_halted = 1'b1; hs_req = 1'b1;      // cycle 0
    for (int c = 1; c <= 5; c++) begin
      step(1);
      if (c == 3) hs_req = 1'b0;            // second SETTLE cycle
      chk($sformatf("ab_gnt_c%0d", c), hs_gnt, 0);
      chk($sformatf("ab_we_c%0d", c), ram_we, 0);
    end
    chk("ab_busy_c5", hs_busy, 0);
    cpu_halted = 1'b0;
    step(2);

    // User pause overlap: halt ack early so grant comes at cycle 6
    user_pause = 1'b1;
    step(1);
    chk("up_pause_idle", cpu_pause_n, 0);
    cpu_halted = 1'b1; hs_req = 1'b1;      // cycle 0
    step(5);                                // cycle 5
    chk("up_gnt_c5", hs_gnt, 0);
    step(1);                                // cycle 6
    chk("up_gnt_c6", hs_gnt, 1);
    hs_req = 1'b0;
    step(2);                                // cycle 8: IDLE
    chk("up_busy", hs_busy, 0); chk("up_pause_held", cpu_pause_n, 0);
    user_pause = 1'b0; cpu_halted = 1'b0;
    step(1);
    chk("up_pause_off", cpu_pause_n, 1);
    step(2);

    // Reset in the middle of a granted write
    cpu_halted = 1'b1; hs_req = 1'b1;      // cycle 0
    step(6);                                // cycle 6: GRANT
    chk("rg_gnt", hs_gnt, 1);
    hs_addr = 16'h0777; hs_wdata = 8'h5A; hs_we = 1'b1;
    step(1);                                // cycle 7
    chk("rg_we", ram_we, 1);
    reset = 1'b1;
    #1;
    chk("rg_async_sel", ram_sel, 0); chk("rg_async_we", ram_we, 0);
    chk("rg_async_gnt", hs_gnt, 0);  chk("rg_async_pause", cpu_pause_n, 1);
    step(1);
    chk("rg_hold_we", ram_we, 0); chk("rg_hold_addr", ram_addr, 0);
    chk("rg_hold_busy", hs_busy, 0);
    hs_req = 1'b0; hs_we = 1'b0; cpu_halted = 1'b0;
    reset = 1'b0;
    step(2);
    chk("rg_after_busy", hs_busy, 0); chk("rg_after_sel", ram_sel, 0);
    chk("rg_after_pause", cpu_pause_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
